// File: rtl/cpu_phase_controller.sv
// 8-phase instruction sequencer for the 5-bit-address RISC core.
// Drives the address mux select plus memory, register-load and halt controls.
module cpu_phase_controller #(
    parameter int OPCODE_WIDTH = 3,
    parameter int PHASE_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    en,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    output logic                    sel,
    output logic                    rd,
    output logic                    wr,
    output logic                    ld_ir,
    output logic                    ld_ac,
    output logic                    ld_pc,
    output logic                    inc_pc,
    output logic                    data_e,
    output logic                    halt,
    output logic [PHASE_WIDTH-1:0]  phase
);

    // phase      | meaning
    // INST_ADDR  | PC drives the address mux
    // INST_FETCH | instruction read from memory
    // INST_LOAD  | IR captures the instruction
    // IDLE       | IR load held, opcode settles
    // OP_ADDR    | PC increments, HLT detected here
    // OP_FETCH   | operand read for ALU ops
    // ALU_OP     | SKZ skip, JMP load, STO drives bus
    // STORE      | ACC load, STO write strobe
    typedef enum logic [PHASE_WIDTH-1:0] {
        INST_ADDR,
        INST_FETCH,
        INST_LOAD,
        IDLE,
        OP_ADDR,
        OP_FETCH,
        ALU_OP,
        STORE
    } phase_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(7);

    phase_t phase_q, phase_d;
    logic   halted_q, halted_d;

    logic is_alu, is_skz, is_sto, is_jmp, is_hlt;
    logic ld_ir_raw, inc_pc_raw, ld_pc_raw, ld_ac_raw, wr_raw;

    assign is_hlt = (opcode == OP_HLT);
    assign is_skz = (opcode == OP_SKZ);
    assign is_sto = (opcode == OP_STO);
    assign is_jmp = (opcode == OP_JMP);
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (en && !halted_q) begin
            phase_d = phase_t'(phase_q + 1'b1);
            if (phase_q == OP_ADDR && is_hlt) begin
                halted_d = 1'b1;
            end
        end
    end

    // Opcode is only looked at from OP_ADDR onward, so an unsettled IR
    // during the fetch phases cannot leak into any output.
    always_comb begin
        sel        = 1'b0;
        rd         = 1'b0;
        data_e     = 1'b0;
        halt       = 1'b0;
        ld_ir_raw  = 1'b0;
        inc_pc_raw = 1'b0;
        ld_pc_raw  = 1'b0;
        ld_ac_raw  = 1'b0;
        wr_raw     = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel       = 1'b1;
                    rd        = 1'b1;
                    ld_ir_raw = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc_raw = 1'b1;
                end
                OP_FETCH: begin
                    rd = is_alu;
                end
                ALU_OP: begin
                    rd         = is_alu;
                    inc_pc_raw = is_skz & zero;
                    ld_pc_raw  = is_jmp;
                    data_e     = is_sto;
                end
                STORE: begin
                    rd        = is_alu;
                    ld_ac_raw = is_alu;
                    ld_pc_raw = is_jmp;
                    data_e    = is_sto;
                    wr_raw    = is_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    // Strobes are gated by en so a stall never repeats one.
    assign ld_ir  = ld_ir_raw  & en;
    assign inc_pc = inc_pc_raw & en;
    assign ld_pc  = ld_pc_raw  & en;
    assign ld_ac  = ld_ac_raw  & en;
    assign wr     = wr_raw     & en;
    assign phase  = phase_q;

endmodule

// File: tb/tb_cpu_phase_controller.sv
// Scoreboard bench for cpu_phase_controller: a reference model pushes the
// expected output vector per cycle, which is popped and compared to the DUT.
module tb_cpu_phase_controller;

    logic       clk;
    logic       n_rst;
    logic       en;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [2:0] phase;

    cpu_phase_controller #(.OPCODE_WIDTH(3), .PHASE_WIDTH(3)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .en     (en),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];

    int   m_phase  = 0;
    logic m_halted = 1'b0;

    wire [11:0] dut_out = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase};

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3,
                           XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b (sel rd wr ir ac pc inc de halt phase)",
                     tag, got, want);
        end
    endtask

    function automatic logic [11:0] model_out(input int p, input logic h, input logic e,
                                              input logic [2:0] op, input logic z);
        logic s, r, w, ir, ac, pc, inc, de, alu;
        s = 0; r = 0; w = 0; ir = 0; ac = 0; pc = 0; inc = 0; de = 0;
        if (h) return {9'b0000_0000_1, p[2:0]};
        s   = (p <= 3);
        r   = (p >= 1 && p <= 3);
        ir  = e && (p == 2 || p == 3);
        inc = e && (p == 4);
        if (p >= 5) begin
            alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
            r   = alu;
            if (p >= 6) begin
                de = (op == STO);
                pc = e && (op == JMP);
            end
            if (p == 6) inc = e && (op == SKZ) && z;
            if (p == 7) begin
                ac = e && alu;
                w  = e && (op == STO);
            end
        end
        return {s, r, w, ir, ac, pc, inc, de, 1'b0, p[2:0]};
    endfunction

    task automatic step(input string tag, input logic e, input logic [2:0] op, input logic z);
        logic [11:0] want;
        @(negedge clk);
        en = e; opcode = op; zero = z;
        exp_q.push_back(model_out(m_phase, m_halted, e, op, z));
        #1;
        want = exp_q.pop_front();
        chk(tag, dut_out, want);
        if (e && !m_halted) begin
            if (m_phase == 4 && op == HLT) m_halted = 1'b1;
            m_phase = (m_phase + 1) % 8;
        end
    endtask

    // mode 0: opcode stable all instruction; 1: X before phase 3; 2: random before phase 3
    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input int mode, input int stall_ph, input int stall_len,
                             input int stop_at);
        logic [2:0] xv;
        logic [2:0] cur;
        xv = 3'bxxx;
        for (int p = 0; p < stop_at; p++) begin
            cur = op;
            if (p < 3 && mode == 1) cur = xv;
            if (p < 3 && mode == 2) cur = 3'($urandom_range(0, 7));
            if (p == stall_ph) begin
                for (int k = 0; k < stall_len; k++) step({tag, "_stall"}, 1'b0, cur, z);
            end
            step(tag, 1'b1, cur, z);
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 n_rst = 1'b0;
        m_phase = 0;
        m_halted = 1'b0;
        exp_q.push_back(12'h800);
        #1 chk(tag, dut_out, exp_q.pop_front());
        @(posedge clk);
        #2 n_rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; en = 1'b0; opcode = ADD; zero = 1'b0;
        exp_q.push_back(12'h800);
        #1 chk("reset", dut_out, exp_q.pop_front());
        #10 n_rst = 1'b1;

        run_instr("add",   ADD,  1'b0, 0, 8, 0, 8);
        run_instr("add2",  ADD,  1'b0, 2, 8, 0, 8);
        run_instr("sto",   STO,  1'b0, 0, 8, 0, 8);
        run_instr("skz_z", SKZ,  1'b1, 0, 8, 0, 8);
        run_instr("skz_n", SKZ,  1'b0, 0, 8, 0, 8);
        run_instr("jmp",   JMP,  1'b1, 2, 8, 0, 8);
        run_instr("and_x", AND_, 1'b0, 1, 8, 0, 8);
        run_instr("lda",   LDA,  1'b1, 1, 8, 0, 8);
        run_instr("xor",   XOR_, 1'b0, 2, 8, 0, 8);
        run_instr("stall", ADD,  1'b0, 0, 2, 3, 8);
        run_instr("sto_st", STO, 1'b0, 0, 7, 2, 8);

        // async reset in phase 6, between clock edges
        run_instr("mid", JMP, 1'b0, 0, 8, 0, 7);
        #1 n_rst = 1'b0;
        m_phase = 0;
        m_halted = 1'b0;
        exp_q.push_back(12'h800);
        #1 chk("async_rst", dut_out, exp_q.pop_front());
        @(posedge clk);
        #2 n_rst = 1'b1;
        run_instr("post_rst", ADD, 1'b0, 0, 8, 0, 8);

        // halt with a stall in phase 4, then 20 halted cycles
        run_instr("hlt", HLT, 1'b0, 0, 4, 2, 8);
        for (int i = 0; i < 20; i++)
            step("halted", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
        pulse_reset("hlt_rst");
        run_instr("resume", SKZ, 1'b1, 2, 8, 0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
